// File: rtl/key_pkg.sv
// Shared definitions for the key conditioner: per-channel FSM state encoding
// and the 50 MHz default debounce / long-press counts.
package key_pkg;

    localparam int unsigned CNT_W = 26;

    // 20 ms and 1 s at 50 MHz, expressed as "cycles minus one".
    localparam logic [CNT_W-1:0] DEB_20MS = 26'd999_999;
    localparam logic [CNT_W-1:0] HOLD_1S  = 26'd49_999_999;

    // One-hot channel state.
    typedef enum logic [3:0] {
        ST_IDLE      = 4'b0001,
        ST_PRESS_DEB = 4'b0010,
        ST_DOWN      = 4'b0100,
        ST_REL_DEB   = 4'b1000
    } key_state_e;

endpackage

// File: rtl/key_filter_ch.sv
// One key channel: two-flop synchroniser, press/release debounce FSM,
// long-press counter and registered event outputs.
//
// Ports:
//   sclk        - system clock
//   nrst        - asynchronous active-low reset
//   key_in      - raw key, active-low, asynchronous to sclk
//   key_press   - one-cycle pulse on debounced press
//   key_release - one-cycle pulse on debounced release
//   key_long    - one-cycle pulse once per press held long enough
//   key_level   - debounced pressed level (1 = held)
module key_filter_ch
    import key_pkg::*;
#(
    parameter logic [CNT_W-1:0] DEB_MAX  = DEB_20MS,
    parameter logic [CNT_W-1:0] LONG_MAX = HOLD_1S
) (
    input  logic sclk,
    input  logic nrst,
    input  logic key_in,
    output logic key_press,
    output logic key_release,
    output logic key_long,
    output logic key_level
);

    logic             key_meta_q;
    logic             key_s_q;
    key_state_e       state_q,     state_d;
    logic [CNT_W-1:0] deb_cnt_q,   deb_cnt_d;
    logic [CNT_W-1:0] long_cnt_q,  long_cnt_d;
    logic             long_done_q, long_done_d;
    logic             press_q,     press_d;
    logic             release_q,   release_d;
    logic             long_q,      long_d;
    logic             level_q,     level_d;

    // Synchroniser; both flops reset to "released".
    always_ff @(posedge sclk or negedge nrst) begin
        if (!nrst) begin
            key_meta_q <= 1'b1;
            key_s_q    <= 1'b1;
        end else begin
            key_meta_q <= key_in;
            key_s_q    <= key_meta_q;
        end
    end

    // State, counters and output registers.
    always_ff @(posedge sclk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= ST_IDLE;
            deb_cnt_q   <= '0;
            long_cnt_q  <= '0;
            long_done_q <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
            level_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            deb_cnt_q   <= deb_cnt_d;
            long_cnt_q  <= long_cnt_d;
            long_done_q <= long_done_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
            level_q     <= level_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        deb_cnt_d   = '0;
        long_cnt_d  = long_cnt_q;
        long_done_d = long_done_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        long_d      = 1'b0;
        level_d     = 1'b0;

        // Bounce checks are tested before the terminal count, so a sample
        // that disagrees always wins over acceptance in the same cycle.
        unique case (state_q)
            ST_IDLE: begin
                if (!key_s_q) begin
                    state_d = ST_PRESS_DEB;
                end
            end
            ST_PRESS_DEB: begin
                if (key_s_q) begin
                    state_d = ST_IDLE;
                end else if (deb_cnt_q == DEB_MAX) begin
                    state_d = ST_DOWN;
                    press_d = 1'b1;
                end else begin
                    deb_cnt_d = deb_cnt_q + CNT_W'(1);
                end
            end
            ST_DOWN: begin
                if (key_s_q) begin
                    state_d = ST_REL_DEB;
                end
            end
            ST_REL_DEB: begin
                if (!key_s_q) begin
                    state_d = ST_DOWN;
                end else if (deb_cnt_q == DEB_MAX) begin
                    state_d   = ST_IDLE;
                    release_d = 1'b1;
                end else begin
                    deb_cnt_d = deb_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Hold time accumulates only while settled down; release bounces
        // pause it rather than restarting it.
        if ((state_q == ST_DOWN) && (long_cnt_q != LONG_MAX)) begin
            long_cnt_d = long_cnt_q + CNT_W'(1);
        end

        // The done flag limits the long event to one per press even though
        // the counter stays saturated.
        if ((long_cnt_q == LONG_MAX) && !long_done_q) begin
            long_d      = 1'b1;
            long_done_d = 1'b1;
        end

        if (state_d == ST_IDLE) begin
            long_cnt_d  = '0;
            long_done_d = 1'b0;
        end

        level_d = (state_d == ST_DOWN) || (state_d == ST_REL_DEB);
    end

    assign key_press   = press_q;
    assign key_release = release_q;
    assign key_long    = long_q;
    assign key_level   = level_q;

endmodule

// File: rtl/key_pulse_gen.sv
// Multi-channel push-button conditioner: turns raw bouncing active-low keys
// into clean single-cycle press / release / long-press pulses plus a
// debounced level, one independent key_filter_ch per channel.
//
// Ports:
//   sclk        - system clock (50 MHz)
//   nrst        - asynchronous active-low reset
//   key_in      - raw keys, active-low, asynchronous to sclk
//   key_press   - one-cycle pulse per debounced press
//   key_release - one-cycle pulse per debounced release
//   key_long    - one-cycle pulse once per long hold
//   key_level   - debounced pressed level, 1 = held
module key_pulse_gen
    import key_pkg::*;
#(
    parameter int unsigned      KEY_W    = 4,
    parameter logic [CNT_W-1:0] DEB_MAX  = DEB_20MS,
    parameter logic [CNT_W-1:0] LONG_MAX = HOLD_1S
) (
    input  logic             sclk,
    input  logic             nrst,
    input  logic [KEY_W-1:0] key_in,
    output logic [KEY_W-1:0] key_press,
    output logic [KEY_W-1:0] key_release,
    output logic [KEY_W-1:0] key_long,
    output logic [KEY_W-1:0] key_level
);

    // One fully independent filter per key.
    for (genvar g = 0; g < KEY_W; g++) begin : g_ch
        key_filter_ch #(
            .DEB_MAX  (DEB_MAX),
            .LONG_MAX (LONG_MAX)
        ) u_ch (
            .sclk        (sclk),
            .nrst        (nrst),
            .key_in      (key_in[g]),
            .key_press   (key_press[g]),
            .key_release (key_release[g]),
            .key_long    (key_long[g]),
            .key_level   (key_level[g])
        );
    end

endmodule

// File: tb/tb_key_pulse_gen.sv
// Bench for key_pulse_gen: directed scenarios plus random key activity,
// checked every cycle against a run-length reference model via a queue.
module tb_key_pulse_gen;

    localparam int W = 2;
    localparam int D = 4;
    localparam int L = 20;

    logic           sclk = 1'b0;
    logic           nrst = 1'b0;
    logic [W-1:0]   key_in = '1;
    logic [W-1:0]   key_press, key_release, key_long, key_level;

    key_pulse_gen #(
        .KEY_W    (W),
        .DEB_MAX  (26'd4),
        .LONG_MAX (26'd20)
    ) dut (
        .sclk        (sclk),
        .nrst        (nrst),
        .key_in      (key_in),
        .key_press   (key_press),
        .key_release (key_release),
        .key_long    (key_long),
        .key_level   (key_level)
    );

    always #5 sclk = ~sclk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Expected vector layout: {level, long, release, press}.
    logic [4*W-1:0] exp_q[$];

    // Reference model: the debounced level flips after D+2 consecutive
    // synchronised samples that disagree with it; the long event fires
    // once the hold time (cycles settled down) has reached L.
    bit           m_s1[W];
    bit           m_s2[W];
    bit           m_lvl[W];
    int           m_run[W];
    int           m_hold[W];
    bit           m_done[W];
    bit           m_pressed;
    bit           m_fire;
    logic [4*W-1:0] m_e;

    always @(posedge sclk) begin
        cyc++;
        m_e = '0;
        for (int i = 0; i < W; i++) begin
            if (!nrst) begin
                m_s1[i] = 1'b1; m_s2[i] = 1'b1; m_lvl[i] = 1'b0;
                m_run[i] = 0;   m_hold[i] = 0;  m_done[i] = 1'b0;
            end else begin
                m_pressed = (m_s2[i] == 1'b0);
                m_fire    = (m_hold[i] == L) && !m_done[i];
                if (m_fire) m_done[i] = 1'b1;
                if (m_lvl[i] && m_run[i] == 0 && m_hold[i] < L) m_hold[i]++;
                if (m_pressed != m_lvl[i]) m_run[i]++;
                else m_run[i] = 0;
                if (m_run[i] == D + 2) begin
                    m_lvl[i] = !m_lvl[i];
                    m_run[i] = 0;
                    if (m_lvl[i]) begin
                        m_e[i] = 1'b1;
                    end else begin
                        m_e[W+i]  = 1'b1;
                        m_hold[i] = 0;
                        m_done[i] = 1'b0;
                    end
                end
                m_e[2*W+i] = m_fire;
                m_e[3*W+i] = m_lvl[i];
                m_s2[i] = m_s1[i];
                m_s1[i] = key_in[i];
            end
        end
        exp_q.push_back(m_e);
    end

    // Observed pulse history, used by the directed scenario checks.
    int press_cnt[W];
    int rel_cnt[W];
    int long_cnt[W];
    int press_edge[W];
    int long_edge[W];

    // Monitor: compare every output cycle against the model's expectation.
    initial begin
        logic [4*W-1:0] got, exp_v;
        for (int i = 0; i < W; i++) begin
            press_cnt[i] = 0; rel_cnt[i] = 0; long_cnt[i] = 0;
            press_edge[i] = 0; long_edge[i] = 0;
        end
        forever begin
            @(posedge sclk);
            #1;
            got = {key_level, key_long, key_release, key_press};
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL outputs cyc=%0d no expectation queued, got=%h", cyc, got);
            end else begin
                exp_v = exp_q.pop_front();
                if (got !== exp_v) begin
                    failures++;
                    $display("FAIL outputs cyc=%0d got=%h exp=%h", cyc, got, exp_v);
                end
            end
            for (int i = 0; i < W; i++) begin
                if (key_press[i])   begin press_cnt[i]++; press_edge[i] = cyc; end
                if (key_release[i]) rel_cnt[i]++;
                if (key_long[i])    begin long_cnt[i]++;  long_edge[i]  = cyc; end
            end
        end
    end

    task automatic check(input string name, input int got, input int exp_v);
        checks++;
        if (got !== exp_v) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp_v);
        end
    endtask

    // Drive v for exactly n sampling edges; first_edge is the first of them.
    task automatic hold(input logic [W-1:0] v, input int n, output int first_edge);
        @(negedge sclk);
        key_in     = v;
        first_edge = cyc + 1;
        repeat (n - 1) @(negedge sclk);
    endtask

    initial begin
        int k, k1, p0, r0, l0, r;
        logic [W-1:0] cur;
        int rate;

        // Reset defaults and idle keys.
        key_in = '1;
        nrst   = 1'b0;
        repeat (5) @(negedge sclk);
        nrst = 1'b1;
        hold(2'b11, 50, k);
        check("idle_press_cnt", press_cnt[0] + press_cnt[1], 0);
        check("idle_long_cnt",  long_cnt[0] + long_cnt[1], 0);

        // Clean press on channel 0 held past the long time.
        l0 = long_cnt[0];
        hold(2'b10, 40, k);
        check("press_latency", press_edge[0] - k, D + 3);
        check("long_latency",  long_edge[0] - press_edge[0], L + 1);
        check("long_once",     long_cnt[0] - l0, 1);
        hold(2'b11, 20, k);
        check("level_after_release", int'(key_level[0]), 0);

        // Bounce rejection, then a genuine press.
        p0 = press_cnt[0];
        hold(2'b10, 3, k);
        hold(2'b11, 2, k);
        hold(2'b10, 3, k);
        hold(2'b11, 12, k);
        check("bounce_no_press", press_cnt[0] - p0, 0);
        hold(2'b10, 10, k);
        check("press_after_bounce", press_cnt[0] - p0, 1);
        hold(2'b10, 5, k);

        // Release bounce keeps the level up, then one release.
        r0 = rel_cnt[0];
        hold(2'b11, 2, k);
        hold(2'b10, 1, k);
        check("level_through_bounce", int'(key_level[0]), 1);
        hold(2'b11, 15, k);
        check("release_once", rel_cnt[0] - r0, 1);
        check("level_released", int'(key_level[0]), 0);

        // Channel independence: presses two edges apart stay two apart.
        hold(2'b10, 2, k);
        hold(2'b00, 30, k1);
        check("ch_spacing", press_edge[1] - press_edge[0], 2);
        hold(2'b11, 40, k);

        // Reset while held down: silent abort, then a fresh press.
        hold(2'b10, 15, k);
        r0 = rel_cnt[0];
        p0 = press_cnt[0];
        @(negedge sclk);
        nrst = 1'b0;
        repeat (3) @(negedge sclk);
        check("reset_level", int'(key_level[0]), 0);
        nrst = 1'b1;
        r    = cyc + 1;
        repeat (12) @(negedge sclk);
        check("reset_no_release", rel_cnt[0] - r0, 0);
        check("reset_repress_cnt", press_cnt[0] - p0, 1);
        check("reset_repress_lat", press_edge[0] - r, D + 3);
        hold(2'b11, 20, k);

        // Random key activity with varying bounce density.
        cur = '1;
        for (int blk = 0; blk < 6; blk++) begin
            case ($urandom_range(0, 2))
                0:       rate = 3;
                1:       rate = 12;
                default: rate = 40;
            endcase
            for (int c = 0; c < 500; c++) begin
                for (int i = 0; i < W; i++) begin
                    if ($urandom_range(0, rate - 1) == 0) cur[i] = ~cur[i];
                end
                @(negedge sclk);
                key_in = cur;
            end
        end
        hold(2'b11, 30, k);
        @(negedge sclk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
